round_robin_write_register_file: RTL and testbench
==================================================

ROUND_ROBIN_WRITE_REGISTER_FILE -- requirements
Module: round_robin_write_register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data bits per word.
REQ-002 SHALL have parameter CHANNELS, default 4, number of write channels, legal range 2..8.
REQ-003 SHALL have parameter DEPTH, default 8, number of register words, power of two, 2..64; AW = clog2(DEPTH).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port write_request  input  CHANNELS  per-channel write request, bit i = channel i.
REQ-007 SHALL have port write_data  input  CHANNELS*WIDTH  packed data, channel i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port write_addr  input  CHANNELS*AW  packed addresses, channel i at bits [i*AW +: AW].
REQ-009 SHALL have port write_grant  output  CHANNELS  one-hot grant, combinational, same cycle as request.
REQ-010 SHALL have port read_enable  input  1  read request.
REQ-011 SHALL have port read_addr  input  AW  read word address.
REQ-012 SHALL have port read_data  output  WIDTH  registered read result.
REQ-013 SHALL have port read_valid  output  1  high exactly one cycle after an accepted read.

Function
REQ-014 SHALL hold a round-robin pointer ptr (clog2(CHANNELS) bits), the highest-priority channel.
REQ-015 SHALL grant the first requesting channel found searching ptr, ptr+1, ... modulo CHANNELS; at most one grant bit high.
REQ-016 SHALL drive write_grant all-zero when write_request is all-zero.
REQ-017 SHALL, on each edge with a grant to channel g, write write_data[g] into word write_addr[g] and set ptr to (g+1) mod CHANNELS.
REQ-018 SHALL leave ptr and all words unchanged on edges with no grant.
REQ-019 SHALL, on an edge with read_enable high, load read_data with word read_addr and set read_valid high for the next cycle; otherwise read_valid low and read_data holds.
REQ-020 SHALL, when read and granted write target the same word on one edge, return the old (pre-write) value; new value visible to reads on following edges.
REQ-021 SHALL accept reads and writes concurrently every cycle; write latency 1 cycle, read latency 1 cycle.
REQ-022 SHALL let a channel held requesting keep priority rotation: with all CHANNELS requesting continuously, each channel granted exactly once per CHANNELS cycles.
REQ-023 SHALL keep ungranted channels' requests pending only by the requester holding write_request; no internal queueing.

Reset
REQ-024 SHALL, on an edge with reset_n low, clear all words to 0, ptr to 0, read_data to 0, read_valid to 0.
REQ-025 SHALL give reset priority over any concurrent write or read on the same edge; the write is discarded.
REQ-026 SHALL drive write_grant to all-zero while reset_n is low.

Structure
REQ-027 SHALL place default parameter constants and a clog2 helper function in shared package rr_regfile_pkg.
REQ-028 SHALL implement grant selection and pointer update in sub-module rr_arbiter (parameter CHANNELS; ports clk, reset_n, request, grant).
REQ-029 SHALL keep storage, address decode and read register in the top module.

Verification
REQ-030 SHALL cover reset: write ch0 0xAAAA to addr 3, pull reset_n low one edge, read addr 3 -> read_data 0x0000, read_valid 1 one cycle later.
REQ-031 SHALL cover rotation: all 4 channels request continuously for 8 cycles -> grants 0001,0010,0100,1000,0001,0010,0100,1000.
REQ-032 SHALL cover sparse requests: ptr=0, only ch2 requests -> grant 0100, next cycle ch1 and ch2 request -> grant 0010? no: ptr=3 so order 3,0,1 -> grant 0010.
REQ-033 SHALL cover read-during-write: addr 5 holds 0x1234, ch1 writes 0xBEEF to addr 5 while reading addr 5 -> read_data 0x1234; next read -> 0xBEEF.
REQ-034 SHALL cover contention loss: ch0 and ch3 both target addr 7 with 0x0001/0x0003, ptr=0 -> cycle1 writes 0x0001, ch3 held -> cycle2 writes 0x0003; read addr 7 -> 0x0003.
REQ-035 SHALL cover idle: no requests, no read for 10 cycles -> write_grant 0, read_valid 0, ptr and words unchanged.

Source files
------------

// File: rtl/rr_regfile_pkg.sv
// ---------------------------------------------------------------------------
// rr_regfile_pkg
// Shared constants and helpers for the round-robin write register file.
//   WIDTH_DEFAULT    : default data bits per word
//   CHANNELS_DEFAULT : default number of write channels
//   DEPTH_DEFAULT    : default number of register words
//   clog2()          : ceiling log2, used for address and pointer widths
// ---------------------------------------------------------------------------
package rr_regfile_pkg;

    localparam int WIDTH_DEFAULT    = 16;
    localparam int CHANNELS_DEFAULT = 4;
    localparam int DEPTH_DEFAULT    = 8;

    // Smallest r with 2**r >= value; usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter for the register file write channels.
//   clk      : rising-edge clock
//   reset_n  : synchronous active-low reset, clears the priority pointer
//   request  : per-channel request, bit i = channel i
//   grant    : one-hot combinational grant, all-zero with no request or
//              while reset_n is low
// The pointer names the highest-priority channel and moves to the channel
// after the winner on every edge that carries a grant.
// ---------------------------------------------------------------------------
module rr_arbiter
    import rr_regfile_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] request,
    output logic [CHANNELS-1:0] grant
);

    localparam int PW = clog2(CHANNELS);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] candidate;
    logic [PW-1:0] winner;
    logic          found;

    // Search ptr, ptr+1, ... modulo CHANNELS and grant the first requester.
    // Reset masks the grant so no write can sneak through a reset edge.
    always_comb begin
        grant     = '0;
        found     = 1'b0;
        winner    = '0;
        candidate = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            candidate = PW'((int'(ptr_q) + i) % CHANNELS);
            if (!found && request[candidate]) begin
                grant[candidate] = 1'b1;
                winner           = candidate;
                found            = 1'b1;
            end
        end
        if (!reset_n) begin
            grant = '0;
            found = 1'b0;
        end
    end

    // Next pointer: the channel after the winner, wrapping explicitly
    // because CHANNELS need not be a power of two.
    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            if (int'(winner) == CHANNELS - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner + 1'b1;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/round_robin_write_register_file.sv
// ---------------------------------------------------------------------------
// round_robin_write_register_file
// Register file with CHANNELS write ports arbitrated round-robin (one write
// per cycle) and one registered read port.
//   clk           : rising-edge clock
//   reset_n       : synchronous active-low reset, clears words and read port
//   write_request : per-channel write request
//   write_data    : packed write data, channel i at [i*WIDTH +: WIDTH]
//   write_addr    : packed write addresses, channel i at [i*AW +: AW]
//   write_grant   : one-hot combinational grant
//   read_enable   : read request
//   read_addr     : read word address
//   read_data     : registered read result (pre-write value on collision)
//   read_valid    : high the cycle after an accepted read
// ---------------------------------------------------------------------------
module round_robin_write_register_file
    import rr_regfile_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter int CHANNELS = CHANNELS_DEFAULT,
    parameter int DEPTH    = DEPTH_DEFAULT
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [CHANNELS-1:0]                 write_request,
    input  logic [CHANNELS*WIDTH-1:0]           write_data,
    input  logic [CHANNELS*clog2(DEPTH)-1:0]    write_addr,
    output logic [CHANNELS-1:0]                 write_grant,
    input  logic                                read_enable,
    input  logic [clog2(DEPTH)-1:0]             read_addr,
    output logic [WIDTH-1:0]                    read_data,
    output logic                                read_valid
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] read_data_q;
    logic             read_valid_q;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arbiter (
        .clk     (clk),
        .reset_n (reset_n),
        .request (write_request),
        .grant   (write_grant)
    );

    // The grant is one-hot, so at most one channel's slice is selected.
    always_comb begin
        wr_en   = |write_grant;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (write_grant[i]) begin
                wr_addr = write_addr[i*AW +: AW];
                wr_data = write_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Storage; reset wins over any write on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port samples the array before this edge's write lands, which
    // gives old-data semantics on a same-word read/write collision.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            read_valid_q <= read_enable;
            if (read_enable) begin
                read_data_q <= mem_q[read_addr];
            end
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;

endmodule

// File: tb/tb_round_robin_write_register_file.sv
// ---------------------------------------------------------------------------
// tb_round_robin_write_register_file
// Directed scenarios with literal expectations, then randomized traffic,
// all shadowed by a behavioural model compared against the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_round_robin_write_register_file;

    logic        clk;
    logic        reset_n;
    logic [3:0]  write_request;
    logic [63:0] write_data;
    logic [11:0] write_addr;
    logic [3:0]  write_grant;
    logic        read_enable;
    logic [2:0]  read_addr;
    logic [15:0] read_data;
    logic        read_valid;

    int errors;
    int checks;

    // Behavioural model state.
    logic [15:0] mMem [8];
    int          mPtr;
    logic [15:0] mRd;
    logic        mRv;
    bit          modelReady;

    round_robin_write_register_file #(
        .WIDTH    (16),
        .CHANNELS (4),
        .DEPTH    (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .write_request (write_request),
        .write_data    (write_data),
        .write_addr    (write_addr),
        .write_grant   (write_grant),
        .read_enable   (read_enable),
        .read_addr     (read_addr),
        .read_data     (read_data),
        .read_valid    (read_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one value and log a failure line when it differs.
    task automatic checkEq(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // First requesting channel searching from the model pointer, or -1.
    function automatic int modelWinner();
        for (int k = 0; k < 4; k++) begin
            if (write_request[(mPtr + k) % 4] === 1'b1) return (mPtr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] modelGrant();
        int g;
        if (!reset_n) return 4'b0000;
        g = modelWinner();
        if (g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    // Model update on each rising edge: read sees the old word, then write.
    always @(posedge clk) begin
        int g;
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) mMem[i] = 16'h0000;
            mPtr       = 0;
            mRd        = 16'h0000;
            mRv        = 1'b0;
            modelReady = 1'b1;
        end else if (modelReady) begin
            g = modelWinner();
            if (read_enable) begin
                mRd = mMem[read_addr];
                mRv = 1'b1;
            end else begin
                mRv = 1'b0;
            end
            if (g >= 0) begin
                mMem[write_addr[g*3 +: 3]] = write_data[g*16 +: 16];
                mPtr = (g + 1) % 4;
            end
        end
    end

    // Every-cycle comparison on the falling edge, away from the active edge.
    task automatic checkOutput();
        checkEq("model_grant", {28'd0, write_grant}, {28'd0, modelGrant()});
        checkEq("model_read_valid", {31'd0, read_valid}, {31'd0, mRv});
        checkEq("model_read_data", {16'd0, read_data}, {16'd0, mRd});
    endtask

    always @(negedge clk) begin
        if (modelReady) checkOutput();
    end

    // Drive one cycle of inputs, capture the grant mid-cycle, return #1
    // after the following rising edge so registered outputs are settled.
    task automatic applyStimulus(input logic [3:0] req, input logic [63:0] wd, input logic [11:0] wa,
                                 input logic ren, input logic [2:0] ra, output logic [3:0] grantSeen);
        write_request = req;
        write_data    = wd;
        write_addr    = wa;
        read_enable   = ren;
        read_addr     = ra;
        @(negedge clk);
        grantSeen = write_grant;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] gs;
    logic [3:0] rotExp [8];

    initial begin
        errors        = 0;
        checks        = 0;
        modelReady    = 1'b0;
        reset_n       = 1'b0;
        write_request = '0;
        write_data    = '0;
        write_addr    = '0;
        read_enable   = 1'b0;
        read_addr     = '0;
        rotExp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        applyStimulus(4'b0000, '0, '0, 1'b0, 3'd0, gs);
        applyStimulus(4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 12'o7777, 1'b1, 3'd0, gs);
        checkEq("reset_grant_zero", {28'd0, gs}, 32'h0);
        checkEq("reset_valid", {31'd0, read_valid}, 32'h0);
        checkEq("reset_data", {16'd0, read_data}, 32'h0);
        reset_n = 1'b1;

        // Reset clears a previously written word.
        applyStimulus(4'b0001, 64'h0000_0000_0000_AAAA, 12'o0003, 1'b0, 3'd0, gs);
        checkEq("pre_reset_write_grant", {28'd0, gs}, 32'h1);
        applyStimulus(4'b0000, '0, '0, 1'b1, 3'd3, gs);
        checkEq("pre_reset_read", {16'd0, read_data}, 32'hAAAA);
        reset_n = 1'b0;
        applyStimulus(4'b0000, '0, '0, 1'b0, 3'd0, gs);
        reset_n = 1'b1;
        applyStimulus(4'b0000, '0, '0, 1'b1, 3'd3, gs);
        checkEq("post_reset_read", {16'd0, read_data}, 32'h0000);
        checkEq("post_reset_valid", {31'd0, read_valid}, 32'h1);

        // Rotation with every channel requesting.
        for (int c = 0; c < 8; c++) begin
            applyStimulus(4'b1111, 64'h1003_1002_1001_1000, 12'o3210, 1'b0, 3'd0, gs);
            checkEq($sformatf("rotation_%0d", c), {28'd0, gs}, {28'd0, rotExp[c]});
        end
        applyStimulus(4'b0000, '0, '0, 1'b1, 3'd2, gs);
        checkEq("rotation_word2", {16'd0, read_data}, 32'h1002);

        // Sparse requests: ch2 alone, then ch1+ch2 with priority at ch3.
        applyStimulus(4'b0100, '0, '0, 1'b0, 3'd0, gs);
        checkEq("sparse_ch2", {28'd0, gs}, 32'h4);
        applyStimulus(4'b0110, '0, '0, 1'b0, 3'd0, gs);
        checkEq("sparse_ch1", {28'd0, gs}, 32'h2);

        // Read during write returns the old value.
        applyStimulus(4'b0001, 64'h0000_0000_0000_1234, 12'o0005, 1'b0, 3'd0, gs);
        checkEq("rdw_setup_grant", {28'd0, gs}, 32'h1);
        applyStimulus(4'b0010, 64'h0000_0000_BEEF_0000, 12'o0050, 1'b1, 3'd5, gs);
        checkEq("rdw_grant", {28'd0, gs}, 32'h2);
        checkEq("rdw_old", {16'd0, read_data}, 32'h1234);
        applyStimulus(4'b0000, '0, '0, 1'b1, 3'd5, gs);
        checkEq("rdw_new", {16'd0, read_data}, 32'hBEEF);

        // Contention: bring ptr to 0 via ch3, then ch0 and ch3 hit addr 7.
        applyStimulus(4'b1000, '0, 12'o0000, 1'b0, 3'd0, gs);
        checkEq("contend_setup", {28'd0, gs}, 32'h8);
        applyStimulus(4'b1001, 64'h0003_0000_0000_0001, 12'o7007, 1'b0, 3'd0, gs);
        checkEq("contend_first", {28'd0, gs}, 32'h1);
        applyStimulus(4'b1000, 64'h0003_0000_0000_0001, 12'o7007, 1'b1, 3'd7, gs);
        checkEq("contend_second", {28'd0, gs}, 32'h8);
        checkEq("contend_mid_read", {16'd0, read_data}, 32'h0001);
        applyStimulus(4'b0000, '0, '0, 1'b1, 3'd7, gs);
        checkEq("contend_final", {16'd0, read_data}, 32'h0003);

        // Idle: nothing moves.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(4'b0000, 64'hDEAD_DEAD_DEAD_DEAD, 12'o1234, 1'b0, 3'd0, gs);
            checkEq("idle_grant", {28'd0, gs}, 32'h0);
            checkEq("idle_valid", {31'd0, read_valid}, 32'h0);
        end
        applyStimulus(4'b1111, 64'h0000_0000_0000_5555, 12'o0001, 1'b1, 3'd7, gs);
        checkEq("idle_ptr_kept", {28'd0, gs}, 32'h1);
        checkEq("idle_word_kept", {16'd0, read_data}, 32'h0003);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            applyStimulus(4'($urandom_range(0, 15)),
                          {$urandom(), $urandom()},
                          12'($urandom_range(0, 4095)),
                          1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), gs);
        end
        reset_n = 1'b1;
        applyStimulus(4'b0000, '0, '0, 1'b0, 3'd0, gs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
